// File: rtl/sub_pipe.sv
// Two-stage pipelined unsigned subtractor with valid/ready flow control.
// Stage 1 resolves the low SPLIT bits and their borrow; stage 2 finishes the high chunk.
module sub_pipe #(
    parameter int DATA_WIDTH_1 = 16,
    parameter int DATA_WIDTH_2 = 16,
    parameter int SPLIT        = 8,
    localparam int W = (DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH_1-1:0] data1_i,
    input  logic [DATA_WIDTH_2-1:0] data2_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [W:0]              data_o,
    output logic                    valid_o,
    input  logic                    ready_i
);

    localparam int WH = W - SPLIT;

    logic [W-1:0]     a_ext_s;
    logic [W-1:0]     b_ext_s;
    logic [SPLIT:0]   lo_diff_s;
    logic [WH:0]      hi_diff_s;
    logic             adv1_s;
    logic             adv2_s;

    logic             s1_valid_q, s1_valid_d;
    logic [SPLIT-1:0] s1_lo_q, s1_lo_d;
    logic             s1_borrow_q, s1_borrow_d;
    logic [WH-1:0]    s1_a_hi_q, s1_a_hi_d;
    logic [WH-1:0]    s1_b_hi_q, s1_b_hi_d;
    logic [W:0]       data_q, data_d;
    logic             valid_q, valid_d;

    assign a_ext_s = W'(data1_i);
    assign b_ext_s = W'(data2_i);

    // Flow control and the two halves of the borrow chain
    always_comb begin
        adv2_s    = ~valid_q | ready_i;
        adv1_s    = ~s1_valid_q | adv2_s;
        lo_diff_s = {1'b0, a_ext_s[SPLIT-1:0]} - {1'b0, b_ext_s[SPLIT-1:0]};
        hi_diff_s = {1'b0, s1_a_hi_q} - {1'b0, s1_b_hi_q} - {{WH{1'b0}}, s1_borrow_q};
    end

    // Next-state for stage 1: load on accept, drain when idle, hold when stalled
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_lo_d     = s1_lo_q;
        s1_borrow_d = s1_borrow_q;
        s1_a_hi_d   = s1_a_hi_q;
        s1_b_hi_d   = s1_b_hi_q;
        if (adv1_s) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_lo_d     = lo_diff_s[SPLIT-1:0];
                s1_borrow_d = lo_diff_s[SPLIT];
                s1_a_hi_d   = a_ext_s[W-1:SPLIT];
                s1_b_hi_d   = b_ext_s[W-1:SPLIT];
            end else begin
                s1_lo_d     = s1_lo_q;
                s1_borrow_d = s1_borrow_q;
                s1_a_hi_d   = s1_a_hi_q;
                s1_b_hi_d   = s1_b_hi_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Next-state for stage 2: data only moves when the output slot advances
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv2_s) begin
            valid_d = s1_valid_q;
            data_d  = {hi_diff_s, s1_lo_q};
        end else begin
            valid_d = valid_q;
            data_d  = data_q;
        end
    end

    // Pipeline registers; reset discards any in-flight beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_lo_q     <= {SPLIT{1'b0}};
            s1_borrow_q <= 1'b0;
            s1_a_hi_q   <= {WH{1'b0}};
            s1_b_hi_q   <= {WH{1'b0}};
            data_q      <= {(W+1){1'b0}};
            valid_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_lo_q     <= s1_lo_d;
            s1_borrow_q <= s1_borrow_d;
            s1_a_hi_q   <= s1_a_hi_d;
            s1_b_hi_q   <= s1_b_hi_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
        end
    end

    assign ready_o = adv1_s;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_sub_pipe.sv
// Scoreboard bench for sub_pipe: two configurations, directed corner cases plus random traffic.
module tb_sub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] a_d1, a_d2;
    logic        a_vi, a_ro, a_vo, a_ri;
    logic [16:0] a_do;
    logic [7:0]  b_d1;
    logic [11:0] b_d2;
    logic        b_vi, b_ro, b_vo, b_ri;
    logic [12:0] b_do;

    int checks = 0;
    int failures = 0;
    logic [16:0] qa[$];
    logic [12:0] qb[$];
    bit rand_rdy = 1'b0;

    sub_pipe #(.DATA_WIDTH_1(16), .DATA_WIDTH_2(16), .SPLIT(8)) u_a (
        .clk(clk), .rst_n(rst_n), .data1_i(a_d1), .data2_i(a_d2), .valid_i(a_vi),
        .ready_o(a_ro), .data_o(a_do), .valid_o(a_vo), .ready_i(a_ri)
    );

    sub_pipe #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(12), .SPLIT(4)) u_b (
        .clk(clk), .rst_n(rst_n), .data1_i(b_d1), .data2_i(b_d2), .valid_i(b_vi),
        .ready_o(b_ro), .data_o(b_do), .valid_o(b_vo), .ready_i(b_ri)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: the difference of the two unsigned operands modulo 2^(W+1)
    function automatic logic [16:0] model_a(input int unsigned x, input int unsigned y);
        int unsigned d;
        d = x - y;
        return d[16:0];
    endfunction

    function automatic logic [12:0] model_b(input int unsigned x, input int unsigned y);
        int unsigned d;
        d = x - y;
        return d[12:0];
    endfunction

    // Monitors: pop the oldest expected result whenever a beat is handed downstream
    always @(negedge clk) begin
        #2;
        if (rst_n && a_vo && a_ri) begin
            if (qa.size() == 0) chk("a_spurious_valid", 32'(a_vo), 32'd0);
            else chk("a_data", 32'(a_do), 32'(qa.pop_front()));
        end
        if (rst_n && b_vo && b_ri) begin
            if (qb.size() == 0) chk("b_spurious_valid", 32'(b_vo), 32'd0);
            else chk("b_data", 32'(b_do), 32'(qb.pop_front()));
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_rdy) a_ri = ($urandom_range(0, 3) != 0);
    end

    task automatic send_a(input logic [15:0] x, input logic [15:0] y);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        a_d1 = x; a_d2 = y; a_vi = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            #1;
            if (a_ro) begin
                acc = 1'b1;
                qa.push_back(model_a(32'(x), 32'(y)));
            end
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (!acc) chk("a_accept_timeout", 32'd0, 32'd1);
        #1 a_vi = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] x, input logic [11:0] y);
        bit acc;
        acc = 1'b0;
        @(negedge clk);
        b_d1 = x; b_d2 = y; b_vi = 1'b1;
        for (int c = 0; c < 200 && !acc; c++) begin
            #1;
            if (b_ro) begin
                acc = 1'b1;
                qb.push_back(model_b(32'(x), 32'(y)));
            end
            @(posedge clk);
            if (!acc) @(negedge clk);
        end
        if (!acc) chk("b_accept_timeout", 32'd0, 32'd1);
        #1 b_vi = 1'b0;
    endtask

    task automatic latency_a(input logic [15:0] x, input logic [15:0] y, input string name);
        send_a(x, y);
        @(negedge clk); #3;
        chk({name, "_not_yet"}, 32'(a_vo), 32'd0);
        @(negedge clk); #3;
        chk({name, "_valid"}, 32'(a_vo), 32'd1);
    endtask

    task automatic drain(input string name);
        int c;
        c = 0;
        while ((qa.size() != 0 || qb.size() != 0) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_drain_a"}, 32'(qa.size()), 32'd0);
        chk({name, "_drain_b"}, 32'(qb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_d1 = 16'd0; a_d2 = 16'd0; a_vi = 1'b0; a_ri = 1'b1;
        b_d1 = 8'd0;  b_d2 = 12'd0; b_vi = 1'b0; b_ri = 1'b1;

        @(negedge clk); #1;
        chk("rst_valid_o", 32'(a_vo), 32'd0);
        chk("rst_ready_o", 32'(a_ro), 32'd1);
        chk("rst_data_o",  32'(a_do), 32'd0);
        chk("rst_b_valid_o", 32'(b_vo), 32'd0);
        @(negedge clk); #3 rst_n = 1'b1;

        latency_a(16'h0005, 16'h0003, "lat_first");
        send_a(16'h0003, 16'h0005);
        send_a(16'h0000, 16'hFFFF);
        send_a(16'h0100, 16'h0001);
        send_a(16'hFF00, 16'h00FF);
        send_b(8'hFF, 12'h100);
        send_b(8'hFF, 12'h00F);
        drain("directed");

        // Backpressure: two beats fill the pipe, the third must wait
        @(negedge clk);
        a_ri = 1'b0;
        send_a(16'h0010, 16'h0001);
        send_a(16'h0020, 16'h0002);
        fork
            send_a(16'h0030, 16'h0003);
            begin
                repeat (3) begin
                    @(negedge clk); #3;
                    chk("bp_ready_low",   32'(a_ro), 32'd0);
                    chk("bp_valid_held",  32'(a_vo), 32'd1);
                    chk("bp_data_held",   32'(a_do), 32'h0000F);
                end
                @(negedge clk);
                a_ri = 1'b1;
            end
        join
        drain("backpressure");

        // Reset while stalled with both stages full
        @(negedge clk);
        a_ri = 1'b0;
        send_a(16'h1234, 16'h0034);
        send_a(16'h0042, 16'h0001);
        @(negedge clk); #3;
        rst_n = 1'b0;
        qa.delete();
        #1;
        chk("midrst_valid_o", 32'(a_vo), 32'd0);
        chk("midrst_data_o",  32'(a_do), 32'd0);
        chk("midrst_ready_o", 32'(a_ro), 32'd1);
        a_d1 = 16'h00AA; a_d2 = 16'h0001; a_vi = 1'b1;
        @(negedge clk); #3;
        rst_n = 1'b1;
        a_vi = 1'b0;
        @(negedge clk);
        a_ri = 1'b1;
        repeat (3) begin
            @(negedge clk); #3;
            chk("postrst_empty", 32'(a_vo), 32'd0);
        end
        latency_a(16'h0007, 16'h0002, "lat_postrst");
        drain("postrst");

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom);
            y = 16'($urandom);
            case ($urandom_range(0, 5))
                0: x = 16'h0000;
                1: y = 16'hFFFF;
                2: y = x;
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_a(x, y);
            if ((i % 10) == 0) send_b(8'($urandom), 12'($urandom));
        end
        rand_rdy = 1'b0;
        @(negedge clk);
        a_ri = 1'b1;
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
